// File: rtl/iob_axi_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : iob_axi_bridge_if
// Brief    : AXI4 master-side signal bundle for the native-to-AXI bridge.
// Revision : 1.0
// ============================================================================
interface iob_axi_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [0:0]          m_axi_awid;
    logic [ADDR_W-1:0]   m_axi_awaddr;
    logic [7:0]          m_axi_awlen;
    logic [2:0]          m_axi_awsize;
    logic [1:0]          m_axi_awburst;
    logic                m_axi_awlock;
    logic [3:0]          m_axi_awcache;
    logic [2:0]          m_axi_awprot;
    logic [3:0]          m_axi_awqos;
    logic                m_axi_awvalid;
    logic                m_axi_awready;

    logic [DATA_W-1:0]   m_axi_wdata;
    logic [DATA_W/8-1:0] m_axi_wstrb;
    logic                m_axi_wlast;
    logic                m_axi_wvalid;
    logic                m_axi_wready;

    logic [0:0]          m_axi_bid;
    logic [1:0]          m_axi_bresp;
    logic                m_axi_bvalid;
    logic                m_axi_bready;

    logic [0:0]          m_axi_arid;
    logic [ADDR_W-1:0]   m_axi_araddr;
    logic [7:0]          m_axi_arlen;
    logic [2:0]          m_axi_arsize;
    logic [1:0]          m_axi_arburst;
    logic                m_axi_arlock;
    logic [3:0]          m_axi_arcache;
    logic [2:0]          m_axi_arprot;
    logic [3:0]          m_axi_arqos;
    logic                m_axi_arvalid;
    logic                m_axi_arready;

    logic [0:0]          m_axi_rid;
    logic [DATA_W-1:0]   m_axi_rdata;
    logic [1:0]          m_axi_rresp;
    logic                m_axi_rlast;
    logic                m_axi_rvalid;
    logic                m_axi_rready;

    modport master (
        output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bid, m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface
`default_nettype wire

// File: rtl/iob_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : iob_axi_bridge
// Brief    : Native valid/ready requests to single-beat AXI4 reads and writes.
// Revision : 1.0
// ============================================================================
module iob_axi_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int AXI_ID = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic                err,
    iob_axi_bridge_if.master    m_axi
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RADDR = 3'd1,
        RDATA = 3'd2,
        WRITE = 3'd3,
        WRESP = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic                r_aw_done;
    logic                r_w_done;

    logic w_arvalid;
    logic w_rready;
    logic w_awvalid;
    logic w_wvalid;
    logic w_bready;
    logic w_aw_fire;
    logic w_w_fire;
    logic w_unused;

    assign w_aw_fire = w_awvalid && m_axi.m_axi_awready;
    assign w_w_fire  = w_wvalid  && m_axi.m_axi_wready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_arvalid   = 1'b0;
        w_rready    = 1'b0;
        w_awvalid   = 1'b0;
        w_wvalid    = 1'b0;
        w_bready    = 1'b0;
        ready       = 1'b0;
        err         = 1'b0;
        case (r_state)
            IDLE: begin
                if (valid) begin
                    w_state_nxt = (wstrb != '0) ? WRITE : RADDR;
                end
            end
            RADDR: begin
                w_arvalid = 1'b1;
                if (m_axi.m_axi_arready) begin
                    w_state_nxt = RDATA;
                end
            end
            RDATA: begin
                w_rready = 1'b1;
                if (m_axi.m_axi_rvalid) begin
                    w_state_nxt = DONE;
                end
            end
            WRITE: begin
                // Address and data channels complete independently, in any order.
                w_awvalid = !r_aw_done;
                w_wvalid  = !r_w_done;
                if ((r_aw_done || (!r_aw_done && m_axi.m_axi_awready)) &&
                    (r_w_done  || (!r_w_done  && m_axi.m_axi_wready))) begin
                    w_state_nxt = WRESP;
                end
            end
            WRESP: begin
                w_bready = 1'b1;
                if (m_axi.m_axi_bvalid) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                ready       = 1'b1;
                err         = r_err;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (r_state == IDLE && valid) begin
                r_addr    <= {address[ADDR_W-1:2], 2'b00};
                r_wdata   <= wdata;
                r_wstrb   <= wstrb;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (w_aw_fire) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_fire) begin
                r_w_done <= 1'b1;
            end
            if (r_state == RDATA && m_axi.m_axi_rvalid) begin
                r_rdata <= m_axi.m_axi_rdata;
                r_err   <= m_axi.m_axi_rresp[1];
            end
            if (r_state == WRESP && m_axi.m_axi_bvalid) begin
                r_err <= m_axi.m_axi_bresp[1];
            end
        end
    end

    assign rdata = r_rdata;

    assign m_axi.m_axi_awid    = 1'(AXI_ID);
    assign m_axi.m_axi_awaddr  = r_addr;
    assign m_axi.m_axi_awlen   = 8'd0;
    assign m_axi.m_axi_awsize  = 3'd2;
    assign m_axi.m_axi_awburst = 2'b01;
    assign m_axi.m_axi_awlock  = 1'b0;
    assign m_axi.m_axi_awcache = 4'b0011;
    assign m_axi.m_axi_awprot  = 3'b010;
    assign m_axi.m_axi_awqos   = 4'd0;
    assign m_axi.m_axi_awvalid = w_awvalid;

    assign m_axi.m_axi_wdata   = r_wdata;
    assign m_axi.m_axi_wstrb   = r_wstrb;
    assign m_axi.m_axi_wlast   = 1'b1;
    assign m_axi.m_axi_wvalid  = w_wvalid;
    assign m_axi.m_axi_bready  = w_bready;

    assign m_axi.m_axi_arid    = 1'(AXI_ID);
    assign m_axi.m_axi_araddr  = r_addr;
    assign m_axi.m_axi_arlen   = 8'd0;
    assign m_axi.m_axi_arsize  = 3'd2;
    assign m_axi.m_axi_arburst = 2'b01;
    assign m_axi.m_axi_arlock  = 1'b0;
    assign m_axi.m_axi_arcache = 4'b0011;
    assign m_axi.m_axi_arprot  = 3'b010;
    assign m_axi.m_axi_arqos   = 4'd0;
    assign m_axi.m_axi_arvalid = w_arvalid;
    assign m_axi.m_axi_rready  = w_rready;

    // Only the error bit of each response matters; ids and rlast are fixed by the single-beat protocol.
    assign w_unused = ^{address[1:0], m_axi.m_axi_bid, m_axi.m_axi_bresp[0],
                        m_axi.m_axi_rid, m_axi.m_axi_rresp[0], m_axi.m_axi_rlast};

endmodule
`default_nettype wire

// File: tb/tb_iob_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_iob_axi_bridge
// Brief    : Randomized bench for iob_axi_bridge with an AXI slave and a reference memory model.
// Revision : 1.0
// ============================================================================
module tb_iob_axi_bridge;

    localparam logic [25:0] ATTR_EXP = {1'b0, 8'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b010, 4'd0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    int total = 0;
    int bad   = 0;

    iob_axi_bridge_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    iob_axi_bridge #(.ADDR_W(32), .DATA_W(32), .AXI_ID(0)) dut (
        .clk     (clk),
        .rst     (rst),
        .valid   (valid),
        .address (address),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .rdata   (rdata),
        .ready   (ready),
        .err     (err),
        .m_axi   (axi.master)
    );

    initial forever #5 clk = ~clk;

    // Slave configuration, owned by the test process.
    int          ar_wait = 0, aw_wait = 0, w_wait = 0, r_wait = 0, b_wait = 0;
    logic [1:0]  rresp_cfg = 2'b00, bresp_cfg = 2'b00;
    bit          rd_ovr = 1'b0;
    logic [31:0] rd_ovr_val = '0;

    // Slave state and monitor counters, owned by the slave process.
    logic [31:0] slv_mem [logic [31:0]];
    int          ar_hs = 0, aw_hs = 0, w_hs = 0, r_hs = 0, b_hs = 0;
    int          arv_cyc = 0, awv_cyc = 0, wv_cyc = 0, proto_err = 0;
    int          ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
    bit          r_pend, b_pend, aw_got, w_got;
    logic [31:0] last_araddr = '0, last_awaddr = '0, got_wdata, got_wstrb_w;
    logic [3:0]  got_wstrb;
    logic [25:0] ar_attr = '0, aw_attr = '0;
    logic        wlast_seen = 1'b0;
    logic        p_arvalid, p_awvalid, p_wvalid, p_rready, p_bready;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    logic [3:0]  p_wstrb;

    // Reference model state.
    logic [31:0] exp_mem [logic [31:0]];
    logic [31:0] exp_rdata = '0;

    function automatic logic [31:0] dflt_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                axi.m_axi_arready = 1'b0; axi.m_axi_awready = 1'b0; axi.m_axi_wready = 1'b0;
                axi.m_axi_rvalid = 1'b0;  axi.m_axi_bvalid = 1'b0;
                axi.m_axi_rdata = '0; axi.m_axi_rresp = 2'b00; axi.m_axi_rid = 1'b0; axi.m_axi_rlast = 1'b1;
                axi.m_axi_bresp = 2'b00; axi.m_axi_bid = 1'b0;
                r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
                ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
                p_arvalid = 0; p_awvalid = 0; p_wvalid = 0; p_rready = 0; p_bready = 0;
                p_araddr = '0; p_awaddr = '0; p_wdata = '0; p_wstrb = '0;
            end else begin
                if (p_arvalid && axi.m_axi_arready) begin ar_hs++; last_araddr = p_araddr; r_pend = 1; r_cnt = 0; end
                if (axi.m_axi_rvalid && p_rready) begin r_hs++; axi.m_axi_rvalid = 1'b0; end
                if (p_awvalid && axi.m_axi_awready) begin aw_hs++; last_awaddr = p_awaddr; aw_got = 1; end
                if (p_wvalid && axi.m_axi_wready) begin w_hs++; got_wdata = p_wdata; got_wstrb = p_wstrb; w_got = 1; end
                if (axi.m_axi_bvalid && p_bready) begin b_hs++; axi.m_axi_bvalid = 1'b0; end
                if (aw_got && w_got) begin
                    got_wstrb_w = {last_awaddr[31:2], 2'b00};
                    slv_mem[got_wstrb_w] = merge(slv_mem.exists(got_wstrb_w) ? slv_mem[got_wstrb_w] : dflt_word(got_wstrb_w),
                                                 got_wdata, got_wstrb);
                    aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
                end
                // A valid that vanished without its handshake is a protocol violation.
                if (p_arvalid && !axi.m_axi_arready && !axi.m_axi_arvalid) proto_err++;
                if (p_awvalid && !axi.m_axi_awready && !axi.m_axi_awvalid) proto_err++;
                if (p_wvalid  && !axi.m_axi_wready  && !axi.m_axi_wvalid)  proto_err++;
                if (r_pend) begin
                    if (r_cnt >= r_wait) begin
                        axi.m_axi_rvalid = 1'b1;
                        axi.m_axi_rresp  = rresp_cfg;
                        axi.m_axi_rdata  = rd_ovr ? rd_ovr_val :
                                           (slv_mem.exists(last_araddr) ? slv_mem[last_araddr] : dflt_word(last_araddr));
                        r_pend = 0;
                    end else r_cnt++;
                end
                if (b_pend) begin
                    if (b_cnt >= b_wait) begin
                        axi.m_axi_bvalid = 1'b1; axi.m_axi_bresp = bresp_cfg; b_pend = 0;
                    end else b_cnt++;
                end
                if (axi.m_axi_arvalid) begin
                    arv_cyc++;
                    ar_attr = {axi.m_axi_arid, axi.m_axi_arlen, axi.m_axi_arsize, axi.m_axi_arburst,
                               axi.m_axi_arlock, axi.m_axi_arcache, axi.m_axi_arprot, axi.m_axi_arqos};
                    axi.m_axi_arready = (ar_cnt >= ar_wait); ar_cnt++;
                end else begin axi.m_axi_arready = 1'b0; ar_cnt = 0; end
                if (axi.m_axi_awvalid) begin
                    awv_cyc++;
                    aw_attr = {axi.m_axi_awid, axi.m_axi_awlen, axi.m_axi_awsize, axi.m_axi_awburst,
                               axi.m_axi_awlock, axi.m_axi_awcache, axi.m_axi_awprot, axi.m_axi_awqos};
                    axi.m_axi_awready = (aw_cnt >= aw_wait); aw_cnt++;
                end else begin axi.m_axi_awready = 1'b0; aw_cnt = 0; end
                if (axi.m_axi_wvalid) begin
                    wv_cyc++; wlast_seen = axi.m_axi_wlast;
                    axi.m_axi_wready = (w_cnt >= w_wait); w_cnt++;
                end else begin axi.m_axi_wready = 1'b0; w_cnt = 0; end
                p_arvalid = axi.m_axi_arvalid; p_araddr = axi.m_axi_araddr;
                p_awvalid = axi.m_axi_awvalid; p_awaddr = axi.m_axi_awaddr;
                p_wvalid  = axi.m_axi_wvalid;  p_wdata  = axi.m_axi_wdata; p_wstrb = axi.m_axi_wstrb;
                p_rready  = axi.m_axi_rready;  p_bready = axi.m_axi_bready;
            end
        end
    end

    // Expected outcome of one request, from the bridge's rules and the current slave settings.
    task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         output int lat, output logic [31:0] rd, output logic e);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (s != 4'h0) begin
            exp_mem[wa] = merge(exp_mem.exists(wa) ? exp_mem[wa] : dflt_word(wa), d, s);
            lat = 3 + ((aw_wait > w_wait) ? aw_wait : w_wait) + b_wait;
            e   = bresp_cfg[1];
        end else begin
            exp_rdata = rd_ovr ? rd_ovr_val : (exp_mem.exists(wa) ? exp_mem[wa] : dflt_word(wa));
            lat = 3 + ar_wait + r_wait;
            e   = rresp_cfg[1];
        end
        rd = exp_rdata;
    endtask

    // Issue one native request; lat counts falling edges from request to the ready pulse.
    task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input bit hold,
                       output int lat, output logic [31:0] rd, output logic e,
                       output logic e_after, output logic rdy_after);
        @(negedge clk);
        valid = 1'b1; address = a; wdata = d; wstrb = s;
        lat = 0;
        do begin @(negedge clk); lat++; end while (ready !== 1'b1 && lat < 100);
        rd = rdata; e = err;
        if (!hold) valid = 1'b0;
        @(negedge clk);
        e_after = err; rdy_after = ready;
        valid = 1'b0; wstrb = 4'($urandom); address = $urandom; wdata = $urandom;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got=%b want=0", ready); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got=%b want=0", err); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got=%h want=0", rdata); end
        total++;
        if ({axi.m_axi_arvalid, axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_rready, axi.m_axi_bready} !== 5'b0) begin
            bad++; $display("FAIL reset_axi: got=%b want=00000",
                {axi.m_axi_arvalid, axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_rready, axi.m_axi_bready});
        end
        #2 rst = 1'b0;
        exp_rdata = '0;
        repeat (2) @(negedge clk);
        total++; if (axi.m_axi_arvalid !== 1'b0 || ready !== 1'b0) begin
            bad++; $display("FAIL idle_after_reset: got=%b%b want=00", axi.m_axi_arvalid, ready);
        end
    endtask

    task automatic test_read_basic();
        int lat, xlat; logic [31:0] rd, xrd; logic e, xe, ea, ra;
        ar_wait = 0; r_wait = 0; rresp_cfg = 2'b00; rd_ovr = 1'b1; rd_ovr_val = 32'hDEADBEEF;
        model(32'h200, 32'h0, 4'h0, xlat, xrd, xe);
        txn(32'h200, 32'h0, 4'h0, 1'b0, lat, rd, e, ea, ra);
        rd_ovr = 1'b0;
        total++; if (lat !== 3) begin bad++; $display("FAIL rd_latency: got=%0d want=3", lat); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data: got=%h want=deadbeef", rd); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL rd_err: got=%b want=0", e); end
        total++; if (last_araddr !== 32'h200) begin bad++; $display("FAIL rd_araddr: got=%h want=200", last_araddr); end
        total++; if (ar_attr !== ATTR_EXP) begin bad++; $display("FAIL rd_ar_fields: got=%h want=%h", ar_attr, ATTR_EXP); end
        total++; if (ra !== 1'b0) begin bad++; $display("FAIL rd_ready_width: got=%b want=0", ra); end
    endtask

    task automatic test_write_delayed();
        int lat, xlat, aw0, w0, b0; logic [31:0] rd, xrd; logic e, xe, ea, ra;
        aw_wait = 3; w_wait = 0; b_wait = 1; bresp_cfg = 2'b00;
        aw0 = awv_cyc; w0 = wv_cyc; b0 = b_hs;
        model(32'h107, 32'h12345678, 4'hF, xlat, xrd, xe);
        txn(32'h107, 32'h12345678, 4'hF, 1'b0, lat, rd, e, ea, ra);
        total++; if (last_awaddr !== 32'h104) begin bad++; $display("FAIL wr_awaddr: got=%h want=104", last_awaddr); end
        total++; if (wv_cyc - w0 !== 1) begin bad++; $display("FAIL wr_wvalid_cycles: got=%0d want=1", wv_cyc - w0); end
        total++; if (awv_cyc - aw0 !== 4) begin bad++; $display("FAIL wr_awvalid_cycles: got=%0d want=4", awv_cyc - aw0); end
        total++; if (lat !== xlat) begin bad++; $display("FAIL wr_latency: got=%0d want=%0d", lat, xlat); end
        total++; if (ra !== 1'b0 || b_hs - b0 !== 1) begin bad++; $display("FAIL wr_single_pulse: got=%b/%0d want=0/1", ra, b_hs - b0); end
        total++; if (rd !== xrd) begin bad++; $display("FAIL wr_rdata_kept: got=%h want=%h", rd, xrd); end
        total++; if (aw_attr !== ATTR_EXP || wlast_seen !== 1'b1) begin
            bad++; $display("FAIL wr_aw_fields: got=%h/%b want=%h/1", aw_attr, wlast_seen, ATTR_EXP);
        end
        aw_wait = 0; b_wait = 0;
    endtask

    task automatic test_read_err();
        int lat, xlat; logic [31:0] rd, xrd; logic e, xe, ea, ra;
        rresp_cfg = 2'b10;
        model(32'h104, 32'h0, 4'h0, xlat, xrd, xe);
        txn(32'h104, 32'h0, 4'h0, 1'b0, lat, rd, e, ea, ra);
        rresp_cfg = 2'b00;
        total++; if (e !== 1'b1) begin bad++; $display("FAIL rerr_pulse: got=%b want=1", e); end
        total++; if (ea !== 1'b0 || ra !== 1'b0) begin bad++; $display("FAIL rerr_after: got=%b%b want=00", ea, ra); end
        total++; if (rd !== xrd) begin bad++; $display("FAIL rerr_data: got=%h want=%h", rd, xrd); end
    endtask

    task automatic test_hold();
        int lat, xlat, a0, c0; logic [31:0] rd, xrd; logic e, xe, ea, ra;
        ar_wait = 2; r_wait = 1;
        a0 = ar_hs; c0 = arv_cyc;
        model(32'h80, 32'h0, 4'h0, xlat, xrd, xe);
        txn(32'h80, 32'h0, 4'h0, 1'b1, lat, rd, e, ea, ra);
        repeat (4) @(negedge clk);
        total++; if (ar_hs - a0 !== 1) begin bad++; $display("FAIL hold_ar_count: got=%0d want=1", ar_hs - a0); end
        total++; if (arv_cyc - c0 !== 3) begin bad++; $display("FAIL hold_arvalid_cycles: got=%0d want=3", arv_cyc - c0); end
        total++; if (lat !== xlat || rd !== xrd) begin bad++; $display("FAIL hold_read: got=%0d/%h want=%0d/%h", lat, rd, xlat, xrd); end
        ar_wait = 0; r_wait = 0;
    endtask

    task automatic test_reset_mid();
        int n, lat, xlat, a0; logic [31:0] rd, xrd; logic e, xe, ea, ra;
        r_wait = 20;
        @(negedge clk);
        valid = 1'b1; address = 32'h104; wstrb = 4'h0; wdata = '0;
        n = 0;
        do begin @(negedge clk); n++; end while (axi.m_axi_rready !== 1'b1 && n < 20);
        total++; if (axi.m_axi_rready !== 1'b1) begin bad++; $display("FAIL rstmid_reach_rdata: got=%b want=1", axi.m_axi_rready); end
        #2 rst = 1'b1;
        #1;
        total++; if (axi.m_axi_rready !== 1'b0 || axi.m_axi_arvalid !== 1'b0) begin
            bad++; $display("FAIL rstmid_rready: got=%b%b want=00", axi.m_axi_rready, axi.m_axi_arvalid);
        end
        total++; if (rdata !== 32'h0 || ready !== 1'b0) begin bad++; $display("FAIL rstmid_outputs: got=%h/%b want=0/0", rdata, ready); end
        valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        exp_rdata = '0;
        r_wait = 0;
        a0 = ar_hs;
        model(32'h104, 32'h0, 4'h0, xlat, xrd, xe);
        txn(32'h104, 32'h0, 4'h0, 1'b0, lat, rd, e, ea, ra);
        total++; if (lat !== 3 || rd !== xrd) begin bad++; $display("FAIL rstmid_clean_read: got=%0d/%h want=3/%h", lat, rd, xrd); end
        total++; if (ar_hs - a0 !== 1) begin bad++; $display("FAIL rstmid_ar_count: got=%0d want=1", ar_hs - a0); end
    endtask

    task automatic test_back_to_back();
        int lat, xlat; logic [31:0] rd, xrd; logic e, xe, ea, ra;
        model(32'h40, 32'hCAFEF00D, 4'hF, xlat, xrd, xe);
        txn(32'h40, 32'hCAFEF00D, 4'hF, 1'b0, lat, rd, e, ea, ra);
        total++; if (rd !== xrd) begin bad++; $display("FAIL b2b_rdata_kept: got=%h want=%h", rd, xrd); end
        model(32'h40, 32'h0, 4'h0, xlat, xrd, xe);
        txn(32'h40, 32'h0, 4'h0, 1'b0, lat, rd, e, ea, ra);
        total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL b2b_readback: got=%h want=cafef00d", rd); end
        model(32'h42, 32'h11112222, 4'h3, xlat, xrd, xe);
        txn(32'h42, 32'h11112222, 4'h3, 1'b0, lat, rd, e, ea, ra);
        model(32'h40, 32'h0, 4'h0, xlat, xrd, xe);
        txn(32'h40, 32'h0, 4'h0, 1'b0, lat, rd, e, ea, ra);
        total++; if (rd !== 32'hCAFE2222) begin bad++; $display("FAIL b2b_partial_strobe: got=%h want=cafe2222", rd); end
    endtask

    task automatic test_random();
        int lat, xlat, nrd, nwr, a0, aw0, p0; logic [31:0] rd, xrd, a, d; logic [3:0] s; logic e, xe, ea, ra;
        nrd = 0; nwr = 0; a0 = ar_hs; aw0 = aw_hs; p0 = proto_err;
        for (int i = 0; i < 24; i++) begin
            ar_wait = $urandom_range(0, 3); aw_wait = $urandom_range(0, 3); w_wait = $urandom_range(0, 3);
            r_wait = $urandom_range(0, 3);  b_wait = $urandom_range(0, 3);
            rresp_cfg = 2'($urandom_range(0, 3)); bresp_cfg = 2'($urandom_range(0, 3));
            a = 32'($urandom_range(0, 3)) * 32'h40 + 32'($urandom_range(0, 3));
            d = $urandom;
            s = ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom_range(1, 15));
            if (s == 4'h0) nrd++; else nwr++;
            model(a, d, s, xlat, xrd, xe);
            txn(a, d, s, 1'b0, lat, rd, e, ea, ra);
            total++; if (lat !== xlat) begin bad++; $display("FAIL rnd%0d_latency: got=%0d want=%0d", i, lat, xlat); end
            total++; if (rd !== xrd) begin bad++; $display("FAIL rnd%0d_rdata: got=%h want=%h", i, rd, xrd); end
            total++; if (e !== xe) begin bad++; $display("FAIL rnd%0d_err: got=%b want=%b", i, e, xe); end
            total++; if (ea !== 1'b0 || ra !== 1'b0) begin bad++; $display("FAIL rnd%0d_after: got=%b%b want=00", i, ea, ra); end
        end
        total++; if (ar_hs - a0 !== nrd || aw_hs - aw0 !== nwr) begin
            bad++; $display("FAIL rnd_txn_count: got=%0d/%0d want=%0d/%0d", ar_hs - a0, aw_hs - aw0, nrd, nwr);
        end
        total++; if (proto_err - p0 !== 0) begin bad++; $display("FAIL rnd_valid_dropped: got=%0d want=0", proto_err - p0); end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_delayed();
        test_read_err();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
